// File: rtl/reg_ctx_engine.sv
// ---------------------------------------------------------------------------
// reg_ctx_engine
//   Register-file context save/restore sequencer used on interrupt entry/exit.
//   A save streams every register to a memory frame at BASE_ADDR. A restore
//   reads the frame back and rewrites the register file through its write port.
//   While busy, the CPU mux gives the register-file controls to this block
//   and stalls the core.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   save_req        start a save (sampled only in IDLE, wins over restore)
//   restore_req     start a restore (sampled only in IDLE)
//   busy            engine owns the register file (core stall)
//   done            one-cycle pulse when a save or restore completes
//   rf_sel          register-file inSelect / outBselect
//   rf_we/rf_wdata  register-file write port
//   rf_rdata        register-file outB (combinational read of rf_sel)
//   mem_addr        data memory address, BASE_ADDR + idx (wraps)
//   mem_we/mem_re   memory strobes, accepted only when mem_gnt=1
//   mem_wdata       memory write data
//   mem_rdata       memory read data, valid the cycle after an accepted mem_re
//   mem_gnt         memory grant
//
// Handshake: a memory strobe is held, with address and data stable, until a
// cycle in which mem_gnt=1; that cycle is the transfer. Register-file writes
// need no grant and always complete in the cycle rf_we is high.
// ---------------------------------------------------------------------------
module reg_ctx_engine #(
    parameter int                    NUM_REGS   = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'hFFF0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  save_req,
    input  logic                  restore_req,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            rf_sel,
    output logic                  rf_we,
    output logic [7:0]            rf_wdata,
    input  logic [7:0]            rf_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_gnt
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] frame_addr;

    // Modulo 2^ADDR_WIDTH: a frame near the top of memory wraps to address 0.
    assign frame_addr = BASE_ADDR + ADDR_WIDTH'(idx_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // All outputs are decoded from state only, so reset forces them to 0
    // immediately without waiting for a clock.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        busy      = 1'b0;
        done      = 1'b0;
        rf_sel    = 4'd0;
        rf_we     = 1'b0;
        rf_wdata  = 8'd0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_wdata = 8'd0;

        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (save_req) begin
                    state_d = S_SAVE;
                end else if (restore_req) begin
                    state_d = S_RD;
                end
            end

            S_SAVE: begin
                busy      = 1'b1;
                rf_sel    = 4'(idx_q);
                mem_addr  = frame_addr;
                mem_wdata = rf_rdata;
                mem_we    = 1'b1;
                if (mem_gnt) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            S_RD: begin
                busy     = 1'b1;
                mem_addr = frame_addr;
                mem_re   = 1'b1;
                if (mem_gnt) begin
                    state_d = S_WR;
                end
            end

            // mem_rdata holds the word fetched by the granted read in RD.
            S_WR: begin
                busy     = 1'b1;
                rf_sel   = 4'(idx_q);
                rf_we    = 1'b1;
                rf_wdata = mem_rdata;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_RD;
                end
            end

            // Requests arriving here are dropped; a held request re-triggers
            // once the engine is back in IDLE.
            S_DONE: begin
                done    = 1'b1;
                idx_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

endmodule
